// File: rtl/alu_muldiv_pkg.sv
// Shared ALU control package: op codes for the EX-stage ALU and the mul/div FSM state enum.
package alu_muldiv_pkg;

    localparam int unsigned ALU_OPW = 5;

    typedef enum logic [ALU_OPW-1:0] {
        ALU_AND   = 5'd0,
        ALU_OR    = 5'd1,
        ALU_XOR   = 5'd2,
        ALU_NOR   = 5'd3,
        ALU_LUI   = 5'd4,
        ALU_SLL   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_SLLV  = 5'd8,
        ALU_SRLV  = 5'd9,
        ALU_SRAV  = 5'd10,
        ALU_ADD   = 5'd11,
        ALU_ADDU  = 5'd12,
        ALU_SUB   = 5'd13,
        ALU_SUBU  = 5'd14,
        ALU_SLT   = 5'd15,
        ALU_SLTU  = 5'd16,
        ALU_MULT  = 5'd17,
        ALU_MULTU = 5'd18,
        ALU_DIV   = 5'd19,
        ALU_DIVU  = 5'd20,
        ALU_MFHI  = 5'd21,
        ALU_MFLO  = 5'd22,
        ALU_MTHI  = 5'd23,
        ALU_MTLO  = 5'd24
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_e;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per cycle,
// operand magnitudes latched at start, sign fix-up applied on the final step.
module alu_muldiv_core
    import alu_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic             res_valid_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] ql_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] a_raw_q;
    logic             neg_q, rneg_q, div0_q;

    logic             last;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   add_s, trial;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign last  = (count_q == CW'(WIDTH-1));
    assign a_abs = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = is_div_i ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV: begin
                if (flush_i)   state_d = ST_IDLE;
                else if (last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q == ST_MUL) || (state_q == ST_DIV);
        res_valid_o = busy_o && last && !flush_i;
    end

    // MUL and DIV share the acc/ql pair: acc is partial product or remainder, ql is multiplier or dividend/quotient.
    always_comb begin
        add_s = {1'b0, acc_q} + (ql_q[0] ? {1'b0, opb_q} : '0);
        trial = {acc_q, ql_q[WIDTH-1]} - {1'b0, opb_q};
        if (state_q == ST_DIV) begin
            step_hi = trial[WIDTH] ? {acc_q[WIDTH-2:0], ql_q[WIDTH-1]} : trial[WIDTH-1:0];
            step_lo = {ql_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            step_hi = add_s[WIDTH:1];
            step_lo = {add_s[0], ql_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        if (state_q == ST_DIV) begin
            if (div0_q) begin
                res_hi_o = a_raw_q;
                res_lo_o = '1;
            end else begin
                res_hi_o = rneg_q ? -step_hi : step_hi;
                res_lo_o = neg_q  ? -step_lo : step_lo;
            end
        end else begin
            res_hi_o = prod_fix[2*WIDTH-1:WIDTH];
            res_lo_o = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            acc_q   <= '0;
            ql_q    <= '0;
            opb_q   <= '0;
            a_raw_q <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else if (state_q == ST_IDLE && start_i) begin
            count_q <= '0;
            acc_q   <= '0;
            ql_q    <= a_abs;
            opb_q   <= b_abs;
            a_raw_q <= a_i;
            neg_q   <= is_signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_q  <= is_signed_i && a_i[WIDTH-1];
            div0_q  <= (b_i == '0);
        end else if (busy_o) begin
            count_q <= count_q + CW'(1);
            acc_q   <= step_hi;
            ql_q    <= step_lo;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: combinational single-cycle ops, HI/LO registers and the stall/done
// handshake around the iterative multiply/divide engine.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned OPW   = 5,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   sa,
    output logic [WIDTH-1:0] y,
    output logic             overflow,
    output logic             zero,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum, diff;
    logic             is_md, md_div, md_signed, is_mthi, is_mtlo;
    logic             idle, start;
    logic             busy, res_valid;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        y         = '0;
        overflow  = 1'b0;
        is_md     = 1'b0;
        md_div    = 1'b0;
        md_signed = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        case (op)
            OPW'(ALU_AND):   y = a & b;
            OPW'(ALU_OR):    y = a | b;
            OPW'(ALU_XOR):   y = a ^ b;
            OPW'(ALU_NOR):   y = ~(a | b);
            OPW'(ALU_LUI):   y = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OPW'(ALU_SLL):   y = b << sa;
            OPW'(ALU_SRL):   y = b >> sa;
            OPW'(ALU_SRA):   y = $signed(b) >>> sa;
            OPW'(ALU_SLLV):  y = b << a[SHW-1:0];
            OPW'(ALU_SRLV):  y = b >> a[SHW-1:0];
            OPW'(ALU_SRAV):  y = $signed(b) >>> a[SHW-1:0];
            OPW'(ALU_ADD): begin
                y        = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OPW'(ALU_ADDU):  y = sum;
            OPW'(ALU_SUB): begin
                y        = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OPW'(ALU_SUBU):  y = diff;
            OPW'(ALU_SLT):   y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OPW'(ALU_SLTU):  y = {{(WIDTH-1){1'b0}}, a < b};
            OPW'(ALU_MULT):  begin is_md = 1'b1; md_signed = 1'b1; end
            OPW'(ALU_MULTU): is_md = 1'b1;
            OPW'(ALU_DIV):   begin is_md = 1'b1; md_div = 1'b1; md_signed = 1'b1; end
            OPW'(ALU_DIVU):  begin is_md = 1'b1; md_div = 1'b1; end
            OPW'(ALU_MFHI):  y = hi_q;
            OPW'(ALU_MFLO):  y = lo_q;
            OPW'(ALU_MTHI):  is_mthi = 1'b1;
            OPW'(ALU_MTLO):  is_mtlo = 1'b1;
            default: ;
        endcase
    end

    assign zero = (y == '0);

    // done_q doubles as the DONE-state flag, so idle excludes both busy and DONE.
    assign idle  = !busy && !done_q;
    assign start = in_valid && is_md && !flush && idle;
    assign stall = !rst && (busy || start);

    alu_muldiv_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .is_div_i   (md_div),
        .is_signed_i(md_signed),
        .a_i        (a),
        .b_i        (b),
        .flush_i    (flush),
        .busy_o     (busy),
        .res_hi_o   (res_hi),
        .res_lo_o   (res_lo),
        .res_valid_o(res_valid)
    );

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = res_valid;
        if (res_valid) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end else if (in_valid && !stall) begin
            if (is_mthi) hi_d = a;
            if (is_mtlo) lo_d = a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Testbench for alu_muldiv (WIDTH=32): table-driven combinational vectors plus
// scoreboarded multiply/divide transactions and flush/reset corner sequences.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          flush;
    logic [4:0]    op;
    logic [W-1:0]  a, b;
    logic [4:0]    sa;
    logic [W-1:0]  y, hi, lo;
    logic          overflow, zero, stall, done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } hl_t;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a, b;
        logic [4:0]   sa;
        logic [W-1:0] y;
        logic         ov;
        logic         z;
    } vec_t;

    hl_t  sb_q[$];
    vec_t vt[$];

    alu_muldiv #(.WIDTH(W), .OPW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .op(op),
        .a(a), .b(b), .sa(sa), .y(y), .overflow(overflow), .zero(zero),
        .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic hl_t model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] v);
        hl_t r;
        longint sx, sv, sp;
        longint unsigned ux, uv, up;
        sx = longint'($signed(x));
        sv = longint'($signed(v));
        ux = {32'h0, x};
        uv = {32'h0, v};
        r  = '0;
        case (o)
            ALU_MULT:  begin sp = sx * sv; r.hi = sp[63:32]; r.lo = sp[31:0]; end
            ALU_MULTU: begin up = ux * uv; r.hi = up[63:32]; r.lo = up[31:0]; end
            ALU_DIV: begin
                if (v == '0) begin r.hi = x; r.lo = '1; end
                else begin sp = sx / sv; r.lo = sp[31:0]; sp = sx % sv; r.hi = sp[31:0]; end
            end
            ALU_DIVU: begin
                if (v == '0) begin r.hi = x; r.lo = '1; end
                else begin up = ux / uv; r.lo = up[31:0]; up = ux % uv; r.hi = up[31:0]; end
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic add_vec(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] v,
                           input logic [4:0] s, input logic [W-1:0] ey, input logic eov, input logic ez);
        vec_t t;
        t.op = o; t.a = x; t.b = v; t.sa = s; t.y = ey; t.ov = eov; t.z = ez;
        vt.push_back(t);
    endtask

    task automatic run_md(input string name, input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] v);
        int  stalls   = 0;
        int  done_cyc = -1;
        hl_t e;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; a = x; b = v;
        sb_q.push_back(model(o, x, v));
        for (int c = 0; c < int'(W) + 10; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (done) begin done_cyc = c; break; end
            @(posedge clk); #1;
        end
        chk({name, " done cycle"}, done_cyc, W + 1);
        chk({name, " stall cycles"}, stalls, W + 1);
        if (done_cyc >= 0) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s scoreboard: got done, expected no pending result", name);
            end else begin
                e = sb_q.pop_front();
                chk({name, " hi"}, hi, e.hi);
                chk({name, " lo"}, lo, e.lo);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, " done pulse width"}, done, 1'b0);
    endtask

    initial begin
        bit saw_done;
        rst = 1'b1; in_valid = 1'b1; flush = 1'b0; op = ALU_MULT; a = '0; b = '0; sa = '0;
        #12;
        chk("reset stall", stall, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset hi", hi, '0);
        chk("reset lo", lo, '0);
        in_valid = 1'b0;
        @(negedge clk); rst = 1'b0;

        add_vec(ALU_ADD,  32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b1, 1'b0);
        add_vec(ALU_ADDU, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b0, 1'b0);
        add_vec(ALU_SUB,  32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b1, 1'b0);
        add_vec(ALU_SUBU, 32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b0, 1'b0);
        add_vec(ALU_ADD,  32'h80000000, 32'h80000000, 5'd0,  32'h0,        1'b1, 1'b1);
        add_vec(ALU_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b1, 1'b0);
        add_vec(ALU_SUB,  32'h5,        32'h5,        5'd0,  32'h0,        1'b0, 1'b1);
        add_vec(ALU_SUBU, 32'h0,        32'h1,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0);
        add_vec(ALU_SLT,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0, 1'b0);
        add_vec(ALU_SLTU, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0, 1'b1);
        add_vec(ALU_SRAV, 32'h21,       32'h80000000, 5'd0,  32'hC0000000, 1'b0, 1'b0);
        add_vec(ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b0, 1'b0);
        add_vec(ALU_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0);
        add_vec(ALU_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'hFF00FF00, 1'b0, 1'b0);
        add_vec(ALU_NOR,  32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0);
        add_vec(ALU_LUI,  32'h0,        32'hABCD1234, 5'd0,  32'h12340000, 1'b0, 1'b0);
        add_vec(ALU_SLL,  32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0, 1'b0);
        add_vec(ALU_SRL,  32'h0,        32'h80000000, 5'd4,  32'h08000000, 1'b0, 1'b0);
        add_vec(ALU_SRA,  32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0);
        add_vec(ALU_SLLV, 32'h24,       32'h3,        5'd0,  32'h30,       1'b0, 1'b0);
        add_vec(ALU_SRLV, 32'h1F,       32'hFFFFFFFF, 5'd0,  32'h1,        1'b0, 1'b0);
        add_vec(ALU_MULT, 32'h3,        32'h5,        5'd0,  32'h0,        1'b0, 1'b1);
        add_vec(5'd31,    32'h3,        32'h5,        5'd0,  32'h0,        1'b0, 1'b1);

        foreach (vt[i]) begin
            op = vt[i].op; a = vt[i].a; b = vt[i].b; sa = vt[i].sa;
            #1;
            chk($sformatf("vec%0d y", i), y, vt[i].y);
            chk($sformatf("vec%0d overflow", i), overflow, vt[i].ov);
            chk($sformatf("vec%0d zero", i), zero, vt[i].z);
        end

        // MTHI followed by MFHI
        @(posedge clk); #1;
        in_valid = 1'b1; op = ALU_MTHI; a = 32'h12345678;
        @(posedge clk); #1;
        op = ALU_MFHI; a = '0;
        #1;
        chk("MFHI y", y, 32'h12345678);
        chk("MFHI zero", zero, 1'b0);
        in_valid = 1'b0;

        run_md("MULT -2x3", ALU_MULT, 32'hFFFFFFFE, 32'h3);
        chk("MULT -2x3 hi const", hi, 32'hFFFFFFFF);
        chk("MULT -2x3 lo const", lo, 32'hFFFFFFFA);
        op = ALU_MFLO; #1;
        chk("MFLO y", y, 32'hFFFFFFFA);
        run_md("MULTU max", ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("MULTU hi const", hi, 32'hFFFFFFFE);
        chk("MULTU lo const", lo, 32'h1);
        run_md("DIVU 100/7", ALU_DIVU, 32'd100, 32'd7);
        chk("DIVU lo const", lo, 32'd14);
        chk("DIVU hi const", hi, 32'd2);
        run_md("DIV -7/2", ALU_DIV, 32'hFFFFFFF9, 32'h2);
        chk("DIV lo const", lo, 32'hFFFFFFFD);
        chk("DIV hi const", hi, 32'hFFFFFFFF);
        run_md("DIV 5/0", ALU_DIV, 32'h5, 32'h0);
        chk("DIV0 lo const", lo, 32'hFFFFFFFF);
        chk("DIV0 hi const", hi, 32'h5);
        run_md("DIV -7/0", ALU_DIV, 32'hFFFFFFF9, 32'h0);
        run_md("DIV min/-1", ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_md("DIV 7/-2", ALU_DIV, 32'h7, 32'hFFFFFFFE);
        run_md("MULT min*min", ALU_MULT, 32'h80000000, 32'h80000000);
        for (int i = 0; i < 3; i++) begin
            run_md($sformatf("MULT rnd%0d", i), ALU_MULT, $urandom, $urandom);
            run_md($sformatf("DIVU rnd%0d", i), ALU_DIVU, $urandom, $urandom_range(1, 65535));
            run_md($sformatf("DIV rnd%0d", i), ALU_DIV, $urandom, $urandom);
        end

        // flush asserted in the accept cycle blocks the start
        @(posedge clk); #1;
        in_valid = 1'b1; op = ALU_MULT; a = 32'h3; b = 32'h5; flush = 1'b1;
        #1;
        chk("flush on accept stall", stall, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        #1;
        chk("flush on accept no start", stall, 1'b0);

        // flush in cycle 10 of a MULT leaves HI/LO intact
        in_valid = 1'b1; op = ALU_MTHI; a = 32'h11;
        @(posedge clk); #1;
        op = ALU_MTLO;
        @(posedge clk); #1;
        op = ALU_MULT; a = 32'h3; b = 32'h5;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("flush cycle stall", stall, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("after flush stall", stall, 1'b0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("flush no done", saw_done, 1'b0);
        chk("flush hi kept", hi, 32'h11);
        chk("flush lo kept", lo, 32'h11);

        // async reset mid-DIV
        @(posedge clk); #1;
        in_valid = 1'b1; op = ALU_DIV; a = 32'd100; b = 32'd7;
        repeat (5) @(posedge clk);
        #2;
        chk("pre-rst stall", stall, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst mid-DIV stall", stall, 1'b0);
        chk("rst mid-DIV hi", hi, '0);
        chk("rst mid-DIV lo", lo, '0);
        chk("rst mid-DIV done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("after rst idle", stall, 1'b0);
        run_md("DIVU after rst", ALU_DIVU, 32'd100, 32'd7);

        chk("scoreboard drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1);
    end

endmodule
